// File: rtl/shuffle_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : shuffle_sequencer                                               |
// | Function : fills an external regfile with 0..len-1, then Fisher-Yates      |
// |            shuffles it using LFSR draws reduced by repeated subtraction.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module shuffle_sequencer #(
    parameter int ADDR_W = 4,
    parameter int RAND_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic [RAND_W-1:0] lfsr_q,
    output logic              lfsr_step,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [ADDR_W-1:0] rf_wdata,
    output logic              rf_we,
    input  logic [ADDR_W-1:0] rf_rdata,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] c_DEPTH = {1'b1, {ADDR_W{1'b0}}};

    localparam logic [3:0] c_ST_IDLE = 4'd0;
    localparam logic [3:0] c_ST_FILL = 4'd1;
    localparam logic [3:0] c_ST_PICK = 4'd2;
    localparam logic [3:0] c_ST_MOD  = 4'd3;
    localparam logic [3:0] c_ST_RD_I = 4'd4;
    localparam logic [3:0] c_ST_RD_J = 4'd5;
    localparam logic [3:0] c_ST_WR_I = 4'd6;
    localparam logic [3:0] c_ST_WR_J = 4'd7;
    localparam logic [3:0] c_ST_DONE = 4'd8;

    logic [3:0]        r_state;
    logic [3:0]        w_state_nxt;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_k;
    logic [ADDR_W-1:0] r_i;
    logic [ADDR_W-1:0] r_j;
    logic [RAND_W-1:0] r_rem;
    logic [ADDR_W-1:0] r_tmp_i;
    logic [ADDR_W-1:0] r_tmp_j;

    logic [ADDR_W:0]   w_len_clamp;
    logic [ADDR_W:0]   w_len_m1;
    logic              w_k_last;
    logic              w_len_lt2;
    logic              w_i_is_one;
    logic [RAND_W-1:0] w_i_ext;
    logic              w_rem_gt;
    logic [RAND_W-1:0] w_rem_sub;

    assign w_len_clamp = (len > c_DEPTH) ? c_DEPTH : len;
    assign w_len_m1    = r_len - 1'b1;
    assign w_k_last    = (r_k == w_len_m1);
    assign w_len_lt2   = (r_len[ADDR_W:1] == '0);
    // i never drops below 1 inside the shuffle loop, so zero upper bits mean i==1
    assign w_i_is_one  = (r_i[ADDR_W-1:1] == '0);
    assign w_i_ext     = RAND_W'(r_i);
    assign w_rem_gt    = (r_rem > w_i_ext);
    assign w_rem_sub   = r_rem - w_i_ext - 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len   <= '0;
            r_k     <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_rem   <= '0;
            r_tmp_i <= '0;
            r_tmp_j <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_len <= w_len_clamp;
                        r_k   <= '0;
                    end
                end
                c_ST_FILL: begin
                    r_k <= r_k + 1'b1;
                    if (w_k_last) begin
                        r_i <= w_len_m1[ADDR_W-1:0];
                    end
                end
                c_ST_PICK: r_rem <= lfsr_q;
                c_ST_MOD: begin
                    if (w_rem_gt) begin
                        r_rem <= w_rem_sub;
                    end else begin
                        r_j <= r_rem[ADDR_W-1:0];
                    end
                end
                c_ST_RD_I: r_tmp_i <= rf_rdata;
                c_ST_RD_J: r_tmp_j <= rf_rdata;
                c_ST_WR_J: begin
                    if (!w_i_is_one) begin
                        r_i <= r_i - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        rf_we       = 1'b0;
        lfsr_step   = 1'b0;
        rf_addr     = '0;
        rf_wdata    = '0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (w_len_clamp == '0) ? c_ST_DONE : c_ST_FILL;
                end
            end
            c_ST_FILL: begin
                busy     = 1'b1;
                rf_we    = 1'b1;
                rf_addr  = r_k[ADDR_W-1:0];
                rf_wdata = r_k[ADDR_W-1:0];
                if (w_k_last) begin
                    w_state_nxt = w_len_lt2 ? c_ST_DONE : c_ST_PICK;
                end
            end
            c_ST_PICK: begin
                busy        = 1'b1;
                lfsr_step   = 1'b1;
                w_state_nxt = c_ST_MOD;
            end
            c_ST_MOD: begin
                busy = 1'b1;
                if (!w_rem_gt) begin
                    w_state_nxt = c_ST_RD_I;
                end
            end
            c_ST_RD_I: begin
                busy        = 1'b1;
                rf_addr     = r_i;
                w_state_nxt = c_ST_RD_J;
            end
            c_ST_RD_J: begin
                busy        = 1'b1;
                rf_addr     = r_j;
                w_state_nxt = c_ST_WR_I;
            end
            c_ST_WR_I: begin
                busy        = 1'b1;
                rf_we       = 1'b1;
                rf_addr     = r_i;
                rf_wdata    = r_tmp_j;
                w_state_nxt = c_ST_WR_J;
            end
            c_ST_WR_J: begin
                busy        = 1'b1;
                rf_we       = 1'b1;
                rf_addr     = r_j;
                rf_wdata    = r_tmp_i;
                w_state_nxt = w_i_is_one ? c_ST_DONE : c_ST_PICK;
            end
            c_ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_shuffle_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_shuffle_sequencer                                            |
// | Function : self-checking bench for shuffle_sequencer with a cycle model.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_shuffle_sequencer;

    localparam int ADDR_W = 4;
    localparam int RAND_W = 8;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   len;
    logic [RAND_W-1:0] lfsr_q;
    logic              lfsr_step;
    logic [ADDR_W-1:0] rf_addr;
    logic [ADDR_W-1:0] rf_wdata;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_rdata;
    logic              busy;
    logic              done;

    shuffle_sequencer #(.ADDR_W(ADDR_W), .RAND_W(RAND_W)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .lfsr_q(lfsr_q),
        .lfsr_step(lfsr_step), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .rf_we(rf_we), .rf_rdata(rf_rdata), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // external regfile and draw source
    logic [ADDR_W-1:0] mem [DEPTH];
    logic [RAND_W-1:0] seq [DEPTH];
    int n_draw = 0;
    int base   = 0;

    assign rf_rdata = mem[rf_addr];
    assign lfsr_q   = seq[4'(n_draw - base)];

    always @(posedge clk) begin
        if (rf_we) mem[rf_addr] <= rf_wdata;
        if (lfsr_step) n_draw <= n_draw + 1;
    end

    int tot_busy = 0, tot_done = 0, tot_step = 0, tot_we = 0;
    always @(negedge clk) begin
        if (busy) tot_busy++;
        if (done) tot_done++;
        if (lfsr_step) tot_step++;
        if (rf_we) tot_we++;
    end

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(string nm, int act, int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    typedef struct {
        logic [3:0] ctl;   // {busy, done, we, step}
        bit         ca;
        logic [3:0] a;
        bit         cd;
        logic [3:0] d;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   chk_en = 1'b0;
    logic [ADDR_W-1:0] mdl_mem [DEPTH];
    int exp_busy, exp_we, exp_steps, exp_lc;

    function automatic void push(int b, int dn, int we, int st, int ca, int a, int cd, int d);
        exp_t e;
        e.ctl = {b[0], dn[0], we[0], st[0]};
        e.ca  = ca[0];
        e.a   = a[3:0];
        e.cd  = cd[0];
        e.d   = d[3:0];
        exp_q.push_back(e);
        if (b != 0) exp_busy++;
        if (we != 0) exp_we++;
    endfunction

    // Expected cycle trace of one operation, derived from the shuffle rules directly.
    task automatic build_trace(input int l);
        int lc, r, nm, j;
        logic [ADDR_W-1:0] t;
        lc = (l > DEPTH) ? DEPTH : l;
        exp_lc = lc;
        exp_busy = 0;
        exp_we = 0;
        exp_steps = (lc > 0) ? lc - 1 : 0;
        for (int k = 0; k < lc; k++) begin
            push(1, 0, 1, 0, 1, k, 1, k);
            mdl_mem[k] = 4'(k);
        end
        if (lc >= 2) begin
            for (int i = lc - 1; i >= 1; i--) begin
                r = int'(seq[lc - 1 - i]);
                push(1, 0, 0, 1, 0, 0, 0, 0);
                nm = r / (i + 1) + 1;
                for (int m = 0; m < nm; m++) push(1, 0, 0, 0, 0, 0, 0, 0);
                j = r % (i + 1);
                push(1, 0, 0, 0, 1, i, 0, 0);
                push(1, 0, 0, 0, 1, j, 0, 0);
                push(1, 0, 1, 0, 1, i, 1, int'(mdl_mem[j]));
                push(1, 0, 1, 0, 1, j, 1, int'(mdl_mem[i]));
                t = mdl_mem[i];
                mdl_mem[i] = mdl_mem[j];
                mdl_mem[j] = t;
            end
        end
        push(0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
            end else begin
                cur.ctl = '0; cur.ca = 1'b0; cur.a = '0; cur.cd = 1'b0; cur.d = '0;
            end
            chk("ctl{busy,done,we,step}", int'({busy, done, rf_we, lfsr_step}), int'(cur.ctl));
            if (cur.ca) chk("rf_addr", int'(rf_addr), int'(cur.a));
            if (cur.cd) chk("rf_wdata", int'(rf_wdata), int'(cur.d));
        end
    end

    int d_busy, d_done, d_step, d_we;

    task automatic run_op(input int l, input bit spam);
        int b_busy, b_done, b_step, b_we, cnt;
        @(negedge clk); #1;
        b_busy = tot_busy; b_done = tot_done; b_step = tot_step; b_we = tot_we;
        base  = n_draw;
        start = 1'b1;
        len   = 5'(l);
        build_trace(l);
        if (!spam) begin
            @(negedge clk); #1;
            start = 1'b0;
        end
        cnt = 0;
        while (exp_q.size() > 0 && cnt < 5000) begin
            @(negedge clk); #1;
            cnt++;
            if (spam) begin
                start = 1'b1;
                len   = 5'($urandom);
            end
        end
        start = 1'b0;
        chk("op_complete_left", exp_q.size(), 0);
        exp_q.delete();
        d_busy = tot_busy - b_busy;
        d_done = tot_done - b_done;
        d_step = tot_step - b_step;
        d_we   = tot_we - b_we;
        chk("busy_cycles", d_busy, exp_busy);
        chk("done_pulses", d_done, 1);
        chk("step_pulses", d_step, exp_steps);
        chk("writes", d_we, exp_we);
        for (int k = 0; k < exp_lc; k++) chk($sformatf("mem[%0d]", k), int'(mem[k]), int'(mdl_mem[k]));
    endtask

    initial begin
        logic [DEPTH-1:0] seen;
        rst   = 1'b1;
        start = 1'b0;
        len   = '0;
        for (int k = 0; k < DEPTH; k++) seq[k] = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_outs", int'({busy, done, rf_we, lfsr_step}), 0);
        chk("rst_addr", int'(rf_addr), 0);
        rst = 1'b0;
        @(negedge clk); #1;
        chk_en = 1'b1;

        // len=4 with draws 5,2,7
        seq[0] = 8'd5; seq[1] = 8'd2; seq[2] = 8'd7;
        run_op(4, 1'b0);
        chk("l4_mem0", int'(mem[0]), 0);
        chk("l4_mem1", int'(mem[1]), 3);
        chk("l4_mem2", int'(mem[2]), 2);
        chk("l4_mem3", int'(mem[3]), 1);
        chk("l4_busy", d_busy, 26);
        chk("l4_steps", d_step, 3);
        chk("l4_writes", d_we, 10);

        run_op(1, 1'b0);
        chk("l1_writes", d_we, 1);
        chk("l1_steps", d_step, 0);
        run_op(0, 1'b0);
        chk("l0_writes", d_we, 0);
        chk("l0_busy", d_busy, 0);

        // free-running 8-bit LFSR seeded 0xA5
        seq[0] = 8'hA5;
        for (int k = 1; k < DEPTH; k++)
            seq[k] = {seq[k-1][6:0], seq[k-1][7] ^ seq[k-1][5] ^ seq[k-1][4] ^ seq[k-1][3]};
        run_op(16, 1'b0);
        chk("l16_steps", d_step, 15);
        seen = '0;
        for (int k = 0; k < DEPTH; k++) seen[mem[k]] = 1'b1;
        chk("l16_perm", int'(seen), 16'hFFFF);

        // start held through a whole run, then a fresh start right after done
        for (int k = 0; k < DEPTH; k++) seq[k] = 8'($urandom);
        run_op(8, 1'b1);
        run_op(5, 1'b0);

        // reset in the middle of MOD
        seq[0] = 8'd200;
        @(negedge clk); #1;
        base  = n_draw;
        start = 1'b1;
        len   = 5'd8;
        build_trace(8);
        @(negedge clk); #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk_en = 1'b0;
        exp_q.delete();
        chk("pre_rst_busy", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_we", int'(rf_we), 0);
        chk("arst_step", int'(lfsr_step), 0);
        @(negedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) mdl_mem[k] = 4'(k);
        @(negedge clk); #1;
        chk_en = 1'b1;
        seq[0] = 8'd9; seq[1] = 8'd4;
        run_op(3, 1'b0);

        // len beyond depth clamps
        for (int k = 0; k < DEPTH; k++) seq[k] = 8'($urandom);
        run_op(20, 1'b0);
        chk("l20_steps", d_step, 15);
        seen = '0;
        for (int k = 0; k < DEPTH; k++) seen[mem[k]] = 1'b1;
        chk("l20_perm", int'(seen), 16'hFFFF);

        for (int n = 0; n < 10; n++) begin
            for (int k = 0; k < DEPTH; k++) seq[k] = 8'($urandom);
            run_op(int'($urandom_range(0, 20)), 1'b0);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shuffle_sequencer.md
Name: shuffle_sequencer

Overview:
Top-level sequencer for the LFSR scrambler. On start it fills the external register file with the identity permutation 0..len-1. It then runs a Fisher-Yates shuffle from i=len-1 down to 1: it steps the external LFSR, reduces the random value modulo i+1 by repeated subtraction, and swaps entries i and j through the regfile's single address port. It owns the regfile port and the LFSR step strobe for the whole operation.

Parameters:
ADDR_W, 4, regfile address width; DEPTH = 2^ADDR_W entries; entry data width = ADDR_W
RAND_W, 8, width of LFSR output consumed per draw

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle request; sampled only in IDLE
len  input  ADDR_W+1  number of entries to shuffle; sampled with start; values > DEPTH clamp to DEPTH
lfsr_q  input  RAND_W  current LFSR value, combinational from LFSR register
lfsr_step  output  1  advance LFSR one step (one-cycle pulse)
rf_addr  output  ADDR_W  regfile address, read or write
rf_wdata  output  ADDR_W  regfile write data
rf_we  output  1  regfile write enable
rf_rdata  input  ADDR_W  regfile read data, combinational on rf_addr
busy  output  1  high while an operation is in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async): state=IDLE; all outputs 0; internal registers i, j, k, rem, tmp_i and tmp_j are cleared. Regfile contents are not touched. Reset mid-operation abandons the shuffle, leaving the regfile partially permuted.
- Outputs are registered-state decodes. rf_we, lfsr_step and done are 0 in every state that does not drive them.
- IDLE: busy=0. If start=1, latch len_r=min(len,DEPTH) and set k=0. If len_r=0, go to DONE; otherwise go to FILL.
- FILL: busy=1, rf_we=1, rf_addr=k, rf_wdata=k. Increment k each cycle. On k=len_r-1: if len_r<2, go to DONE; else set i=len_r-1 and go to PICK.
- PICK: busy=1, lfsr_step=1. rem<=lfsr_q, which is the value before the step. Go to MOD.
- MOD: busy=1, one comparison per cycle, using zero-extended width arithmetic:
  - if rem>i, rem<=rem-(i+1) and stay in MOD;
  - else j<=rem and go to RD_I.
  - Exit cycle included, MOD takes floor(r/(i+1))+1 cycles.
- RD_I: rf_addr=i, tmp_i<=rf_rdata. Go to RD_J.
- RD_J: rf_addr=j, tmp_j<=rf_rdata. Go to WR_I.
- WR_I: rf_we=1, rf_addr=i, rf_wdata=tmp_j. Go to WR_J.
- WR_J: rf_we=1, rf_addr=j, rf_wdata=tmp_i. If i=1, go to DONE; else i<=i-1 and go to PICK.
- Self-swap (j=i): all four accesses are still performed; the data is unchanged.
- DONE: busy=0, done=1 for exactly one cycle. Go to IDLE.
- start while not in IDLE (including DONE) is ignored.
- busy rises the cycle after start is accepted. Throughput: the earliest next start is accepted the cycle after done.
- lfsr_step pulses exactly max(len_r-1,0) times per operation.

Test Plan:
- len=4, lfsr_q model yields 5, 2, 7 on successive steps:
  - final regfile {0,3,2,1};
  - busy high for exactly 26 cycles (FILL 4, i=3: 7, i=2: 6, i=1: 9);
  - done pulses once; lfsr_step pulses 3 times.
- len=1 -> one write (addr0=0), then done; lfsr_step never pulses. len=0 -> no writes, done the cycle after start.
- len=16, free-running 8-bit LFSR seeded 0xA5:
  - final contents are a permutation of 0..15;
  - lfsr_step count is 15;
  - rf_addr never exceeds 15.
- start reasserted every cycle during a len=8 run -> a single operation and a single done pulse. start in the cycle after done begins a fresh FILL.
- rst asserted mid-MOD (len=8):
  - busy, done, rf_we and lfsr_step drop to 0 immediately (async);
  - after release a new start with len=3 completes normally.
- len=20 (exceeds DEPTH) -> clamped to 16; exactly 16 FILL writes, addresses 0..15.
